instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//   Boot sequencer for MIPS_Processor: holds the core in reset, streams program bytes from a
//   byte source (bench, UART or debug port) into instruction memory, pads to a word boundary
//   with NOPs (0x00), then releases core reset. Supports reload from RUN and stream timeout.
// PARAMETERS
//   NO_INSTR_BYTES  1024  instruction memory depth in bytes (matches `NO_INSTR_BYTES)
//   MEM_CELL_SIZE   8     bits per memory cell (matches `MEM_CELL_SIZE)
//   ADDR_W          10    byte address width, clog2(NO_INSTR_BYTES)
//   TIMEOUT_CYC     256   max cycles without s_valid during LOAD before error
//   REL_CYC         2     cycles cpu_rst stays high after last write
// PORTS
//   clk        in   1              system clock, all logic rising-edge
//   rst        in   1              synchronous, active-high reset
//   start      in   1              pulse: begin load of load_len bytes
//   load_len   in   ADDR_W+1       byte count to load, 1..NO_INSTR_BYTES
//   s_valid    in   1              source byte valid
//   s_data     in   MEM_CELL_SIZE  source byte, big-endian order (byte 0 = instr[31:24])
//   s_ready    out  1              loader accepts s_data this cycle
//   mem_we     out  1              instruction memory byte write enable
//   mem_addr   out  ADDR_W         instruction memory byte address
//   mem_wdata  out  MEM_CELL_SIZE  instruction memory write data
//   cpu_rst    out  1              reset to MIPS_Processor (active-high)
//   busy       out  1              LOAD/PAD/RELEASE in progress
//   done       out  1              load completed, core running
//   err        out  1              sticky error (bad length or timeout), cleared by start/rst
// BEHAVIOUR
//   Reset: state=IDLE; s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0,
//     done=0, err=0; byte counter, timeout counter, release counter = 0.
//   States: IDLE -> LOAD -> PAD -> RELEASE -> RUN; any -> ERROR.
//   IDLE: cpu_rst=1. start with 1<=load_len<=NO_INSTR_BYTES -> LOAD, ptr=0, err=0.
//     start with load_len==0 or >NO_INSTR_BYTES -> ERROR (err=1 next cycle).
//   LOAD: s_ready=1 while ptr<load_len. Handshake = s_valid&s_ready. Each accepted byte is
//     written next cycle: mem_we=1, mem_addr=ptr, mem_wdata=s_data (1-cycle latency); ptr++.
//     One byte per cycle max; back-to-back accepts sustain 1 byte/cycle. s_ready drops the
//     cycle after the last byte is accepted (ptr==load_len). Then -> PAD if ptr[1:0]!=0,
//     else -> RELEASE.
//   PAD: writes 0x00 at ptr, ptr++, one per cycle, until ptr[1:0]==0; s_ready=0.
//   RELEASE: mem_we=0, cpu_rst=1 for REL_CYC cycles, then -> RUN.
//   RUN: cpu_rst=0, done=1, busy=0. start in RUN -> cpu_rst=1 same edge, done=0, reload via
//     LOAD (same length checks). Memory beyond new length is not cleared.
//   Timeout: in LOAD, counter increments each cycle s_valid=0, clears on handshake; reaching
//     TIMEOUT_CYC -> ERROR. Counter unused in other states.
//   ERROR: err=1, cpu_rst=1, s_ready=0, mem_we=0, busy=0. Only start (valid length) or rst exits.
//   start while busy: ignored. s_valid outside LOAD: ignored, no write.
//   rst mid-load: immediate return to reset values next edge; partially written memory kept.
//   busy=1 in LOAD, PAD, RELEASE only. mem_we never asserted outside LOAD/PAD write cycles.
//   ptr wraps never: length check guarantees ptr<=NO_INSTR_BYTES after padding (depth %4==0).
// TESTING
//   1. rst, start load_len=8, 8 bytes back-to-back (ADDI r1,r0,10; ADD r2,r0,r1) -> writes
//      addr 0..7 exact bytes, no pad, cpu_rst falls 2 cycles after last write, done=1.
//   2. load_len=6, bytes 0x80,0x20,0x00,0x0A,0x04,0x40 -> pad writes 0x00 at addr 6,7,
//      ptr ends 8, done=1.
//   3. s_valid gaps (1 on, 3 off) over 12 bytes -> exactly 12 writes in order, no timeout,
//      s_ready low after byte 12.
//   4. load_len=4, send 2 bytes then stall 256 cycles -> err=1, cpu_rst stays 1, no further
//      writes; start load_len=4 then clears err and loads normally.
//   5. start load_len=0 and load_len=1025 -> err=1, mem_we never asserted, cpu_rst=1.
//   6. From RUN, start load_len=4 -> cpu_rst=1 next cycle, done=0, reload writes addr 0..3;
//      rst asserted mid-load -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot loader: streams program bytes into instruction memory, pads, releases core reset
`timescale 1ns/1ps
module instr_mem_loader #(
  parameter int NO_INSTR_BYTES = 1024,
  parameter int MEM_CELL_SIZE  = 8,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYC    = 256,
  parameter int REL_CYC        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W:0]          load_len,
  input  logic                     s_valid,
  input  logic [MEM_CELL_SIZE-1:0] s_data,
  output logic                     s_ready,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [MEM_CELL_SIZE-1:0] mem_wdata,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PAD  = 3'd2;
  localparam logic [2:0] S_REL  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int RW = $clog2(REL_CYC) + 1;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(NO_INSTR_BYTES);
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0]   R_LAST  = RW'(REL_CYC - 1);

  logic [2:0]      state;
  logic [ADDR_W:0] ptr;
  logic [ADDR_W:0] len_q;
  logic [TW-1:0]   tcnt;
  logic [RW-1:0]   rcnt;
  logic            len_ok;
  logic            start_ok;
  logic            hs;

  assign len_ok   = (load_len != '0) && (load_len <= MAX_LEN);
  assign start_ok = start && ((state == S_IDLE) || (state == S_RUN) || (state == S_ERR));
  assign s_ready  = (state == S_LOAD) && (ptr < len_q);
  assign hs       = s_valid && s_ready;

  // Status outputs decode straight from state so a restart from RUN
  // re-asserts cpu_rst on the same edge that accepts start.
  assign cpu_rst = (state != S_RUN);
  assign done    = (state == S_RUN);
  assign busy    = (state == S_LOAD) || (state == S_PAD) || (state == S_REL);
  assign err     = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      len_q     <= '0;
      tcnt      <= '0;
      rcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        if (len_ok) begin
          state <= S_LOAD;
          ptr   <= '0;
          len_q <= load_len;
          tcnt  <= '0;
        end else begin
          state <= S_ERR;
        end
      end else begin
        case (state)
          S_LOAD: begin
            if (ptr == len_q) begin
              state <= (ptr[1:0] != 2'b00) ? S_PAD : S_REL;
              rcnt  <= '0;
            end else if (hs) begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr[ADDR_W-1:0];
              mem_wdata <= s_data;
              ptr       <= ptr + 1'b1;
              tcnt      <= '0;
            end else if (!s_valid) begin
              if (tcnt == T_LAST) state <= S_ERR;
              else                tcnt  <= tcnt + 1'b1;
            end
          end
          S_PAD: begin
            // Alignment is tested before writing, so the final pad write
            // never lands in the first RELEASE cycle.
            if (ptr[1:0] == 2'b00) begin
              state <= S_REL;
              rcnt  <= '0;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr[ADDR_W-1:0];
              mem_wdata <= '0;
              ptr       <= ptr + 1'b1;
            end
          end
          S_REL: begin
            if (rcnt == R_LAST) state <= S_RUN;
            else                rcnt  <= rcnt + 1'b1;
          end
          S_IDLE, S_RUN, S_ERR: state <= state;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
